// File: rtl/busy_timer_if.sv
// busy_timer control/status bundle: start/abort/mode/period-load in, busy/done/missed/count out.
// The master side drives requests; the slave side (the timer) returns status.
// WIDTH must match the WIDTH of the busy_timer it connects to.
interface busy_timer_if #(
   parameter int WIDTH = 16
);
   logic             i_start;
   logic             i_abort;
   logic [1:0]       i_mode;
   logic             i_load_valid;
   logic [WIDTH-1:0] i_load_value;
   logic             o_busy;
   logic             o_done;
   logic             o_missed;
   logic [WIDTH-1:0] o_count;

   modport master (
      output i_start, i_abort, i_mode, i_load_valid, i_load_value,
      input  o_busy, o_done, o_missed, o_count
   );

   modport slave (
      input  i_start, i_abort, i_mode, i_load_valid, i_load_value,
      output o_busy, o_done, o_missed, o_count
   );
endinterface

// File: rtl/busy_timer.sv
// Busy/tick timer: one-shot, retrigger or periodic down-counter with a loadable period.
// Latency: a start sampled at edge k shows count P-1 after edge k; expiry pulses done as count reaches 0.
// No backpressure: start is level-sampled; a start ignored while busy is flagged by o_missed.
module busy_timer #(
   parameter int WIDTH          = 16,
   parameter int DEFAULT_PERIOD = 22
) (
   input logic        i_clk,
   input logic        i_reset,
   busy_timer_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_ONESHOT     = 2'b00,
      MODE_RETRIG      = 2'b01,
      MODE_PERIODIC    = 2'b10,
      MODE_ONESHOT_ALT = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TWO = {{(WIDTH-2){1'b0}}, 2'b10};

   logic [WIDTH-1:0] count_q, count_n;
   logic [WIDTH-1:0] period_q, period_n;
   mode_e            mode_q, mode_n;
   logic             busy_q, done_q, missed_q;
   logic             done_n, missed_n;
   logic [WIDTH-1:0] reload;
   logic             busy_now;

   // Saturating P-1 so a zero period loads 0 rather than wrapping.
   assign reload   = (period_q == '0) ? '0 : period_q - ONE;
   assign busy_now = (count_q != '0);

   // Next-state: abort beats start/reload, which beats the natural decrement.
   always_comb begin
      count_n  = count_q;
      mode_n   = mode_q;
      done_n   = 1'b0;
      missed_n = 1'b0;
      period_n = bus.i_load_valid ? bus.i_load_value : period_q;

      if (bus.i_abort) begin
         count_n = '0;
      end else if (bus.i_start && (!busy_now || mode_q == MODE_RETRIG)) begin
         // Accepted start always uses the period held before any same-cycle load.
         count_n = reload;
         mode_n  = mode_e'(bus.i_mode);
         // A period of 0 or 1 gives no busy cycle, so expiry is immediate.
         done_n  = (reload == '0);
      end else begin
         if (bus.i_start) begin
            missed_n = 1'b1;
         end
         if (busy_now) begin
            if (count_q == ONE) begin
               done_n = 1'b1;
               // Periodic wrap; periods of 2 or less would never leave 1, so stop instead.
               if (mode_q == MODE_PERIODIC && period_q > TWO) begin
                  count_n = reload;
               end else begin
                  count_n = '0;
               end
            end else begin
               count_n = count_q - ONE;
            end
         end
      end
   end

   // State and registered status outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q  <= '0;
         period_q <= WIDTH'(DEFAULT_PERIOD);
         mode_q   <= MODE_ONESHOT;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         count_q  <= count_n;
         period_q <= period_n;
         mode_q   <= mode_n;
         busy_q   <= (count_n != '0);
         done_q   <= done_n;
         missed_q <= missed_n;
      end
   end

   assign bus.o_count  = count_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_missed = missed_q;

endmodule

// File: tb/tb_busy_timer.sv
// Directed bench for busy_timer (WIDTH=16, DEFAULT_PERIOD=5).
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived constants.
module tb_busy_timer;
   localparam int WIDTH = 16;

   logic i_clk = 1'b0;
   logic i_reset;
   int   checks = 0;
   int   errors = 0;
   int   busy_n;

   busy_timer_if #(.WIDTH(WIDTH)) bus ();

   busy_timer #(.WIDTH(WIDTH), .DEFAULT_PERIOD(5)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int cnt, input logic busy,
                          input logic done, input logic missed);
      chk({tag, ".count"},  32'(bus.o_count), 32'(cnt));
      chk({tag, ".busy"},   32'(bus.o_busy),  32'(busy));
      chk({tag, ".done"},   32'(bus.o_done),  32'(done));
      chk({tag, ".missed"}, 32'(bus.o_missed), 32'(missed));
   endtask

   initial begin
      i_reset          = 1'b1;
      bus.i_start      = 1'b0;
      bus.i_abort      = 1'b0;
      bus.i_mode       = 2'b00;
      bus.i_load_valid = 1'b0;
      bus.i_load_value = '0;
      #12;
      chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
      i_reset = 1'b0;

      // 1: one-shot, P=5 -> 4,3,2,1 busy then 0 with done
      bus.i_start = 1'b1;
      bus.i_mode  = 2'b00;
      tick();
      bus.i_start = 1'b0;
      busy_n = 0;
      for (int c = 4; c >= 1; c--) begin
         chk_all("t1.run", c, 1'b1, 1'b0, 1'b0);
         if (bus.o_busy) busy_n++;
         tick();
      end
      chk_all("t1.expire", 0, 1'b0, 1'b1, 1'b0);
      chk("t1.busy_cycles", 32'(busy_n), 32'd4);
      tick();
      chk("t1.done_clear", 32'(bus.o_done), 32'd0);

      // 2: one-shot, restart attempt while count is 2 is ignored and flagged
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("t2.c4", 32'(bus.o_count), 32'd4);
      tick();
      tick();
      chk("t2.c2", 32'(bus.o_count), 32'd2);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk_all("t2.missed", 1, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("t2.expire", 0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("t2.idle", 0, 1'b0, 1'b0, 1'b0);

      // 3: retrigger; the restart edge replaces the step to 2 -> 4,3,4,3,2,1 then done
      bus.i_mode  = 2'b01;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      busy_n = 0;
      chk("t3.c4", 32'(bus.o_count), 32'd4);
      busy_n++;
      tick();
      chk("t3.c3", 32'(bus.o_count), 32'd3);
      busy_n++;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk_all("t3.retrig", 4, 1'b1, 1'b0, 1'b0);
      busy_n++;
      for (int c = 3; c >= 1; c--) begin
         tick();
         chk_all("t3.run", c, 1'b1, 1'b0, 1'b0);
         if (bus.o_busy) busy_n++;
      end
      tick();
      chk_all("t3.expire", 0, 1'b0, 1'b1, 1'b0);
      chk("t3.busy_cycles", 32'(busy_n), 32'd6);

      // 4: periodic with P=4 -> 3,2,1,3(done),2,1,3(done), then abort
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd4;
      tick();
      bus.i_load_valid = 1'b0;
      bus.i_mode  = 2'b10;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      bus.i_mode  = 2'b00;
      chk_all("t4.c3", 3, 1'b1, 1'b0, 1'b0);
      for (int w = 0; w < 2; w++) begin
         tick();
         chk_all("t4.c2", 2, 1'b1, 1'b0, 1'b0);
         tick();
         chk_all("t4.c1", 1, 1'b1, 1'b0, 1'b0);
         tick();
         chk_all("t4.wrap", 3, 1'b1, 1'b1, 1'b0);
      end
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      chk_all("t4.abort", 0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("t4.after_abort", 0, 1'b0, 1'b0, 1'b0);

      // 5: load 8 mid-run does not disturb the P=5 run; next start gives 7 busy cycles
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd5;
      tick();
      bus.i_load_valid = 1'b0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("t5.c4", 32'(bus.o_count), 32'd4);
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd8;
      tick();
      bus.i_load_valid = 1'b0;
      chk("t5.c3", 32'(bus.o_count), 32'd3);
      tick();
      tick();
      tick();
      chk_all("t5.old_expire", 0, 1'b0, 1'b1, 1'b0);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      busy_n = 0;
      for (int c = 7; c >= 1; c--) begin
         chk("t5.new_run", 32'(bus.o_count), 32'(c));
         if (bus.o_busy) busy_n++;
         tick();
      end
      chk_all("t5.new_expire", 0, 1'b0, 1'b1, 1'b0);
      chk("t5.busy_cycles", 32'(busy_n), 32'd7);
      // load 3 together with start: this start still uses P=8
      bus.i_start      = 1'b1;
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd3;
      tick();
      bus.i_start      = 1'b0;
      bus.i_load_valid = 1'b0;
      chk("t5.same_cycle_old_p", 32'(bus.o_count), 32'd7);
      repeat (7) tick();
      chk_all("t5.same_cycle_expire", 0, 1'b0, 1'b1, 1'b0);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("t5.new_p3", 32'(bus.o_count), 32'd2);
      tick();
      tick();
      chk_all("t5.p3_expire", 0, 1'b0, 1'b1, 1'b0);

      // P=1: no busy cycle, done right after the start edge
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd1;
      tick();
      bus.i_load_valid = 1'b0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk_all("p1.start", 0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("p1.idle", 0, 1'b0, 1'b0, 1'b0);

      // abort together with start leaves the timer idle
      bus.i_load_valid = 1'b1;
      bus.i_load_value = 16'd5;
      tick();
      bus.i_load_valid = 1'b0;
      bus.i_start = 1'b1;
      bus.i_abort = 1'b1;
      tick();
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      chk_all("abort_start", 0, 1'b0, 1'b0, 1'b0);

      // 6: asynchronous reset mid-count, then a fresh start counts DEFAULT_PERIOD-1
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick();
      chk("t6.c3", 32'(bus.o_count), 32'd3);
      i_reset = 1'b1;
      #1;
      chk_all("t6.async", 0, 1'b0, 1'b0, 1'b0);
      tick();
      i_reset = 1'b0;
      chk_all("t6.held", 0, 1'b0, 1'b0, 1'b0);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk_all("t6.restart", 4, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
